// File: rtl/jtag_dbg_pkg.sv
// Shared types and default widths for the system-clock side of the JTAG debug bridge.
package jtag_dbg_pkg;

  localparam int SR_W_DEF    = 38;
  localparam int IR_W_DEF    = 2;
  localparam int ACT_BIT_DEF = 37;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } dbg_state_e;

endpackage

// File: rtl/jtag_dbg_sync_edge.sv
// Three-flop synchroniser for a TCK-domain level with a rising-edge strobe in the clk domain.
module jtag_dbg_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic rise_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
    end
  end

  // sync_q[1] is s2 and sync_q[2] is s3; s1 is only for metastability settling
  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/jtag_debug_cmd_bridge.sv
// Channel-generic JTAG debug command decoder with handshaked action requests.
// Optional ack timeout is built when JTAG_DBG_TIMEOUT_EN is defined.
module jtag_debug_cmd_bridge
  import jtag_dbg_pkg::*;
#(
  parameter int SR_W        = SR_W_DEF,
  parameter int IR_W        = IR_W_DEF,
  parameter int NCH         = 4,
  parameter int ACT_BIT     = ACT_BIT_DEF,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            vs_uir,
  input  logic            vs_udr,
  input  logic [IR_W-1:0] ir_in,
  input  logic [SR_W-1:0] sr,
  input  logic [NCH-1:0]  ack,
  input  logic            clr_err,
  output logic [SR_W-1:0] jdo,
  output logic [IR_W-1:0] ir_cur,
  output logic [NCH-1:0]  take_action,
  output logic [NCH-1:0]  take_no_action,
  output logic            busy,
  output logic            overrun_err,
  output logic            bad_ir_err,
  output logic            timeout_err
);

  localparam logic [IR_W:0] NCH_L = (IR_W+1)'(NCH);

  dbg_state_e      state_q, state_d;
  logic [SR_W-1:0] jdo_q;
  logic [IR_W-1:0] ir_cur_q;
  logic [NCH-1:0]  req_oh_q, tna_q;
  logic            overrun_q, bad_ir_q;
  logic            uir_rise, udr_rise;
  logic [IR_W-1:0] ch;
  logic [NCH-1:0]  ch_oh;
  logic            ch_valid, load_dr, act_req, ack_hit, timeout_hit;

  jtag_dbg_sync_edge u_sync_uir (.clk(clk), .reset_n(reset_n), .async_i(vs_uir), .rise_o(uir_rise));
  jtag_dbg_sync_edge u_sync_udr (.clk(clk), .reset_n(reset_n), .async_i(vs_udr), .rise_o(udr_rise));

  // A simultaneous IR update must steer the DR command, so bypass the latched IR
  assign ch       = (uir_rise & udr_rise) ? ir_in : ir_cur_q;
  assign ch_valid = {1'b0, ch} < NCH_L;
  assign act_req  = sr[ACT_BIT];
  assign load_dr  = udr_rise & (state_q == IDLE);
  assign ack_hit  = |(ack & req_oh_q);

  always_comb begin
    ch_oh = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_oh[i] = (ch == IR_W'(i));
    end
  end

`ifdef JTAG_DBG_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  // Counter sits at zero in IDLE, so every WAIT_ACK entry starts from zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= (state_q == WAIT_ACK) ? cnt_q + 1'b1 : '0;
      timeout_q <= timeout_hit | (timeout_q & ~clr_err);
    end
  end

  assign timeout_hit = (state_q == WAIT_ACK) & ~ack_hit & (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign timeout_err = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (load_dr & act_req & ch_valid) state_d = WAIT_ACK;
      WAIT_ACK: if (ack_hit | timeout_hit)        state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == WAIT_ACK);
    take_action = busy ? req_oh_q : '0;
  end

  // Updates arriving while a request is outstanding are dropped, never queued
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo_q     <= '0;
      ir_cur_q  <= '0;
      req_oh_q  <= '0;
      tna_q     <= '0;
      overrun_q <= 1'b0;
      bad_ir_q  <= 1'b0;
    end else begin
      if (uir_rise) ir_cur_q <= ir_in;
      if (load_dr)  jdo_q    <= sr;
      if (load_dr & act_req & ch_valid) req_oh_q <= ch_oh;
      tna_q     <= (load_dr & ~act_req & ch_valid) ? ch_oh : '0;
      overrun_q <= (udr_rise & (state_q == WAIT_ACK)) | (overrun_q & ~clr_err);
      bad_ir_q  <= (load_dr & ~ch_valid) | (bad_ir_q & ~clr_err);
    end
  end

  assign jdo            = jdo_q;
  assign ir_cur         = ir_cur_q;
  assign take_no_action = tna_q;
  assign overrun_err    = overrun_q;
  assign bad_ir_err     = bad_ir_q;

endmodule
